// File: rtl/rvfi_pc_chain_check.sv
// rvfi_pc_chain_check
//   Windowed PC-continuity checker for the RVFI retirement bus. A start pulse
//   latches base order B. For k = 1..DEPTH the checker then verifies that
//   pc_rdata(B+k) == pc_wdata(B+k-1). Retirements may arrive in any cycle, in
//   any order and on any channel. The first error is held on sticky status
//   outputs.
//
//   Parameters: XLEN (PC width), NRET (retire channels), DEPTH (pairs, 1..16)
//
//   Ports:
//     clock, reset          clock; synchronous active-high reset
//     start, base_order     arm pulse and base order B (ignored while busy)
//     rvfi_valid/order/pc_rdata/pc_wdata   per-channel retirement bus
//     busy                  window armed (TRACK)
//     done                  all DEPTH pairs compared
//     err, err_code         sticky error; code 1 = PC mismatch, 2 = duplicate
//     err_order             successor order (mismatch) or duplicated order
//     err_expect/actual     predecessor wdata / successor rdata at mismatch
//     checked_cnt           pairs compared so far
//
//   Optional: define RVFI_PC_CHAIN_CHECK_ASSERT_EN to add an immediate assert
//   that fires on any mismatch or duplicate.
module rvfi_pc_chain_check #(
  parameter int XLEN  = 32,
  parameter int NRET  = 1,
  parameter int DEPTH = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [63:0]          base_order,
  input  logic [NRET-1:0]      rvfi_valid,
  input  logic [64*NRET-1:0]   rvfi_order,
  input  logic [XLEN*NRET-1:0] rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0] rvfi_pc_wdata,
  output logic                 busy,
  output logic                 done,
  output logic                 err,
  output logic [1:0]           err_code,
  output logic [63:0]          err_order,
  output logic [XLEN-1:0]      err_expect,
  output logic [XLEN-1:0]      err_actual,
  output logic [4:0]           checked_cnt
);

  typedef enum logic [1:0] {IDLE, TRACK, DONE} state_e;

  state_e state_q, state_d;
  logic [63:0] base_q;

  // W slots hold pc_wdata of B+0..B+DEPTH-1; R slots hold pc_rdata of B+1..B+DEPTH
  logic [DEPTH-1:0][XLEN-1:0] w_q;
  logic [DEPTH-1:0]           w_vld_q;
  logic [DEPTH:1][XLEN-1:0]   r_q;
  logic [DEPTH:1]             r_vld_q;
  logic [DEPTH:1]             checked_q, checked_d;

  logic            err_q;
  logic [1:0]      err_code_q;
  logic [63:0]     err_order_q;
  logic [XLEN-1:0] err_expect_q, err_actual_q;

  logic trk, arm;
  assign trk = (state_q == TRACK);
  assign arm = start && (state_q != TRACK);

  // ---- capture: per-slot hit, lowest-channel incoming value, duplicates ----
  logic [NRET-1:0][63:0]      ch_off;
  logic [DEPTH-1:0]           w_hit, w_dup;
  logic [DEPTH-1:0][XLEN-1:0] w_in;
  logic [DEPTH:1]             r_hit, r_dup;
  logic [DEPTH:1][XLEN-1:0]   r_in;

  always_comb begin
    ch_off = '0;
    w_hit  = '0;
    w_dup  = '0;
    w_in   = '0;
    r_hit  = '0;
    r_dup  = '0;
    r_in   = '0;
    for (int c = 0; c < NRET; c++) begin
      // Offset from B, modulo 2^64, so windows spanning the wrap just work.
      ch_off[c] = rvfi_order[64*c +: 64] - base_q;
      if (trk && rvfi_valid[c]) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (ch_off[c] == 64'(k)) begin
            if (w_hit[k]) w_dup[k] = 1'b1;
            else begin
              w_hit[k] = 1'b1;
              w_in[k]  = rvfi_pc_wdata[XLEN*c +: XLEN];
            end
          end
        end
        for (int k = 1; k <= DEPTH; k++) begin
          if (ch_off[c] == 64'(k)) begin
            if (r_hit[k]) r_dup[k] = 1'b1;
            else begin
              r_hit[k] = 1'b1;
              r_in[k]  = rvfi_pc_rdata[XLEN*c +: XLEN];
            end
          end
        end
      end
    end
    // Rewriting an already-filled slot is also a duplicate.
    w_dup = w_dup | (w_hit & w_vld_q);
    r_dup = r_dup | (r_hit & r_vld_q);
  end

  // ---- effective slots and pair compare ----
  // A stored value wins over the incoming one. Same-cycle pairs still
  // compare because an empty slot takes the incoming value.
  logic [DEPTH-1:0]           eff_w_vld;
  logic [DEPTH-1:0][XLEN-1:0] eff_w;
  logic [DEPTH:1]             eff_r_vld;
  logic [DEPTH:1][XLEN-1:0]   eff_r;
  logic [DEPTH:1]             fire;
  logic [DEPTH:0]             mism, dup;

  always_comb begin
    eff_w_vld = '0;
    eff_w     = '0;
    eff_r_vld = '0;
    eff_r     = '0;
    fire      = '0;
    mism      = '0;
    dup       = '0;
    for (int k = 0; k < DEPTH; k++) begin
      eff_w_vld[k] = w_vld_q[k] | w_hit[k];
      eff_w[k]     = w_vld_q[k] ? w_q[k] : w_in[k];
      dup[k]       = dup[k] | w_dup[k];
    end
    for (int k = 1; k <= DEPTH; k++) begin
      eff_r_vld[k] = r_vld_q[k] | r_hit[k];
      eff_r[k]     = r_vld_q[k] ? r_q[k] : r_in[k];
      dup[k]       = dup[k] | r_dup[k];
    end
    for (int k = 1; k <= DEPTH; k++) begin
      fire[k] = trk && eff_w_vld[k-1] && eff_r_vld[k] && !checked_q[k];
      mism[k] = fire[k] && (eff_w[k-1] != eff_r[k]);
    end
    checked_d = checked_q | fire;
  end

  // ---- first-error select: lowest k wins, mismatch beats duplicate ----
  logic            err_hit;
  logic [1:0]      sel_code;
  logic [63:0]     sel_off;
  logic [XLEN-1:0] sel_exp, sel_act;

  always_comb begin
    err_hit  = 1'b0;
    sel_code = 2'd0;
    sel_off  = '0;
    sel_exp  = '0;
    sel_act  = '0;
    // Descending scan: the last assignment is the highest-priority error.
    for (int k = DEPTH; k >= 1; k--) begin
      if (dup[k]) begin
        err_hit  = 1'b1;
        sel_code = 2'd2;
        sel_off  = 64'(k);
        sel_exp  = '0;
        sel_act  = '0;
      end
      if (mism[k]) begin
        err_hit  = 1'b1;
        sel_code = 2'd1;
        sel_off  = 64'(k);
        sel_exp  = eff_w[k-1];
        sel_act  = eff_r[k];
      end
    end
    if (dup[0]) begin
      err_hit  = 1'b1;
      sel_code = 2'd2;
      sel_off  = '0;
      sel_exp  = '0;
      sel_act  = '0;
    end
  end

  // ---- FSM next state ----
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = TRACK;
      TRACK:   if (&checked_d) state_d = DONE;
      DONE:    if (start) state_d = TRACK;
      default: state_d = IDLE;
    endcase
  end

  // ---- state ----
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      w_q          <= '0;
      w_vld_q      <= '0;
      r_q          <= '0;
      r_vld_q      <= '0;
      checked_q    <= '0;
      err_q        <= 1'b0;
      err_code_q   <= 2'd0;
      err_order_q  <= '0;
      err_expect_q <= '0;
      err_actual_q <= '0;
    end else begin
      state_q <= state_d;
      if (arm) begin
        base_q       <= base_order;
        w_vld_q      <= '0;
        r_vld_q      <= '0;
        checked_q    <= '0;
        err_q        <= 1'b0;
        err_code_q   <= 2'd0;
        err_order_q  <= '0;
        err_expect_q <= '0;
        err_actual_q <= '0;
      end else if (trk) begin
        for (int k = 0; k < DEPTH; k++) begin
          if (w_hit[k] && !w_vld_q[k]) begin
            w_q[k]     <= w_in[k];
            w_vld_q[k] <= 1'b1;
          end
        end
        for (int k = 1; k <= DEPTH; k++) begin
          if (r_hit[k] && !r_vld_q[k]) begin
            r_q[k]     <= r_in[k];
            r_vld_q[k] <= 1'b1;
          end
        end
        checked_q <= checked_d;
        if (!err_q && err_hit) begin
          err_q        <= 1'b1;
          err_code_q   <= sel_code;
          err_order_q  <= base_q + sel_off;
          err_expect_q <= sel_exp;
          err_actual_q <= sel_act;
        end
      end
    end
  end

`ifdef RVFI_PC_CHAIN_CHECK_ASSERT_EN
  always_ff @(posedge clock) begin
    if (!reset && trk) begin
      assert (mism == '0 && dup == '0);
    end
  end
`endif

  // ---- outputs ----
  always_comb begin
    checked_cnt = '0;
    for (int k = 1; k <= DEPTH; k++) checked_cnt = checked_cnt + 5'(checked_q[k]);
  end

  assign busy       = (state_q == TRACK);
  assign done       = (state_q == DONE);
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign err_order  = err_order_q;
  assign err_expect = err_expect_q;
  assign err_actual = err_actual_q;

endmodule

// File: tb/tb_rvfi_pc_chain_check.sv
module tb_rvfi_pc_chain_check;
  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic         start2 = 1'b0;
  logic [63:0]  base_order = '0;
  logic [1:0]   vld = '0;
  logic [127:0] ord = '0;
  logic [63:0]  rd = '0;
  logic [63:0]  wd = '0;

  logic        busy, done, err;
  logic [1:0]  err_code;
  logic [63:0] err_order;
  logic [31:0] err_expect, err_actual;
  logic [4:0]  cnt;

  logic        busy2, done2, err2;
  logic [1:0]  err_code2;
  logic [63:0] err_order2;
  logic [31:0] err_expect2, err_actual2;
  logic [4:0]  cnt2;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  rvfi_pc_chain_check #(.XLEN(32), .NRET(2), .DEPTH(4)) dut (
    .clock(clock), .reset(reset), .start(start), .base_order(base_order),
    .rvfi_valid(vld), .rvfi_order(ord), .rvfi_pc_rdata(rd), .rvfi_pc_wdata(wd),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .err_order(err_order), .err_expect(err_expect), .err_actual(err_actual),
    .checked_cnt(cnt)
  );

  // Single-channel, DEPTH=2 instance for the order-wrap window.
  rvfi_pc_chain_check #(.XLEN(32), .NRET(1), .DEPTH(2)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .base_order(base_order),
    .rvfi_valid(vld[0]), .rvfi_order(ord[63:0]), .rvfi_pc_rdata(rd[31:0]),
    .rvfi_pc_wdata(wd[31:0]),
    .busy(busy2), .done(done2), .err(err2), .err_code(err_code2),
    .err_order(err_order2), .err_expect(err_expect2), .err_actual(err_actual2),
    .checked_cnt(cnt2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ret1(input logic [63:0] o, input logic [31:0] r, input logic [31:0] w);
    vld = 2'b01; ord = {64'd0, o}; rd = {32'd0, r}; wd = {32'd0, w};
    tick();
    vld = 2'b00;
  endtask

  task automatic ret2(input logic [63:0] o0, input logic [31:0] r0, input logic [31:0] w0,
                      input logic [63:0] o1, input logic [31:0] r1, input logic [31:0] w1);
    vld = 2'b11; ord = {o1, o0}; rd = {r1, r0}; wd = {w1, w0};
    tick();
    vld = 2'b00;
  endtask

  task automatic arm(input logic [63:0] b);
    start = 1'b1; base_order = b;
    tick();
    start = 1'b0;
  endtask

  initial begin
    // reset
    tick(); tick();
    reset = 1'b0;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_err",  64'(err),  64'd0);
    chk("rst_cnt",  64'(cnt),  64'd0);

    // 1: clean in-order chain
    arm(64'd10);
    chk("t1_busy", 64'(busy), 64'd1);
    ret1(64'd10, 32'h100, 32'h104);
    ret1(64'd11, 32'h104, 32'h108);
    chk("t1_cnt1", 64'(cnt), 64'd1);
    ret1(64'd12, 32'h108, 32'h10C);
    ret1(64'd13, 32'h10C, 32'h110);
    chk("t1_cnt3", 64'(cnt), 64'd3);
    chk("t1_notdone", 64'(done), 64'd0);
    ret1(64'd14, 32'h110, 32'h114);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_busy0", 64'(busy), 64'd0);
    chk("t1_err", 64'(err), 64'd0);
    chk("t1_cnt4", 64'(cnt), 64'd4);

    // 2: mismatch at order 12
    arm(64'd10);
    chk("t2_rearm_done", 64'(done), 64'd0);
    chk("t2_rearm_cnt", 64'(cnt), 64'd0);
    ret1(64'd10, 32'h100, 32'h104);
    ret1(64'd11, 32'h104, 32'h108);
    ret1(64'd12, 32'h200, 32'h10C);
    chk("t2_err", 64'(err), 64'd1);
    chk("t2_code", 64'(err_code), 64'd1);
    chk("t2_order", err_order, 64'd12);
    chk("t2_expect", 64'(err_expect), 64'h108);
    chk("t2_actual", 64'(err_actual), 64'h200);
    ret1(64'd13, 32'h10C, 32'h110);
    ret1(64'd14, 32'h110, 32'h114);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_err_hold", 64'(err), 64'd1);

    // 3: pair on two channels in one cycle, then start ignored while busy
    arm(64'd10);
    chk("t3_err_clr", 64'(err), 64'd0);
    ret2(64'd11, 32'h104, 32'h108, 64'd10, 32'h100, 32'h104);
    chk("t3_cnt1", 64'(cnt), 64'd1);
    chk("t3_err", 64'(err), 64'd0);
    ret2(64'd12, 32'h108, 32'h10C, 64'd13, 32'h10C, 32'h110);
    chk("t3_cnt3", 64'(cnt), 64'd3);
    arm(64'd100);
    chk("t3_ign_busy", 64'(busy), 64'd1);
    chk("t3_ign_cnt", 64'(cnt), 64'd3);
    ret1(64'd14, 32'h110, 32'h114);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_err_end", 64'(err), 64'd0);

    // 4: successor three cycles before predecessor
    arm(64'd20);
    ret1(64'd21, 32'h204, 32'h208);
    tick(); tick();
    chk("t4_cnt0", 64'(cnt), 64'd0);
    ret1(64'd20, 32'h200, 32'h204);
    chk("t4_cnt1", 64'(cnt), 64'd1);
    chk("t4_err", 64'(err), 64'd0);

    // 5: wrap window on dut2 (dut stays armed at base 20 and ignores these)
    start2 = 1'b1; base_order = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    start2 = 1'b0;
    ret1(64'hFFFF_FFFF_FFFF_FFFF, 32'h300, 32'h304);
    ret1(64'd0, 32'h304, 32'h308);
    chk("t5_cnt1", 64'(cnt2), 64'd1);
    ret1(64'd1, 32'h308, 32'h30C);
    chk("t5_done", 64'(done2), 64'd1);
    chk("t5_err", 64'(err2), 64'd0);
    chk("t5_cnt2", 64'(cnt2), 64'd2);
    chk("t5_outside", 64'(cnt), 64'd1);
    chk("t5_outside_err", 64'(err), 64'd0);

    // 6: duplicate order 11, later error ignored, then reset mid-window
    reset = 1'b1; tick(); reset = 1'b0;
    arm(64'd10);
    ret1(64'd10, 32'h100, 32'h104);
    ret1(64'd11, 32'h104, 32'h108);
    ret1(64'd11, 32'h104, 32'h108);
    chk("t6_err", 64'(err), 64'd1);
    chk("t6_code", 64'(err_code), 64'd2);
    chk("t6_order", err_order, 64'd11);
    chk("t6_expect", 64'(err_expect), 64'd0);
    ret1(64'd12, 32'h999, 32'h10C);
    chk("t6_first_only", 64'(err_code), 64'd2);
    chk("t6_cnt", 64'(cnt), 64'd2);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_err", 64'(err), 64'd0);
    chk("t6_rst_code", 64'(err_code), 64'd0);
    chk("t6_rst_cnt", 64'(cnt), 64'd0);

    // 7: two channels hit the same order in one cycle; channel 0 value kept
    arm(64'd10);
    ret2(64'd10, 32'h100, 32'h104, 64'd10, 32'h100, 32'hBAD);
    chk("t7_code", 64'(err_code), 64'd2);
    chk("t7_order", err_order, 64'd10);
    ret1(64'd11, 32'h104, 32'h108);
    chk("t7_cnt", 64'(cnt), 64'd1);
    chk("t7_code_hold", 64'(err_code), 64'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rvfi_pc_chain_check.md
Name: rvfi_pc_chain_check

Overview:
- Windowed PC-continuity checker on the RVFI retirement bus.
- After a start pulse it latches a base order B. It then verifies pc_rdata(B+k) == pc_wdata(B+k-1) for k=1..DEPTH, across all NRET channels.
- Tolerates retirement in any cycle or order and on any channel.
- Reports first failure on sticky status outputs; sits beside the core in the formal/simulation harness, one instance per window.

Parameters:
- XLEN, 32, width of PC fields.
- NRET, 1, number of retirement channels.
- DEPTH, 4, number of consecutive predecessor/successor pairs checked (window covers orders B..B+DEPTH); 1..16.

Ports:
- clock  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; arms a new window.
- base_order  in  64  order B, sampled when start is accepted.
- rvfi_valid  in  NRET  per-channel retire valid.
- rvfi_order  in  64*NRET  per-channel order, channel c at [64*c +: 64].
- rvfi_pc_rdata  in  XLEN*NRET  per-channel PC of retired instruction.
- rvfi_pc_wdata  in  XLEN*NRET  per-channel next PC.
- busy  out  1  window armed (TRACK state).
- done  out  1  all DEPTH pairs compared.
- err  out  1  sticky error flag.
- err_code  out  2  0 none, 1 PC mismatch, 2 duplicate order.
- err_order  out  64  order of the successor (mismatch) or the duplicated order.
- err_expect  out  XLEN  predecessor pc_wdata at first mismatch (0 for duplicate).
- err_actual  out  XLEN  successor pc_rdata at first mismatch (0 for duplicate).
- checked_cnt  out  5  number of pairs compared so far.

Behaviour:
- Reset is decided as: reset, synchronous, active-high; clock is clock.
- Reset values: state IDLE, all slot valid bits 0, all outputs 0.
- States:
  - IDLE -> TRACK on start: latch B; clear slots, checked bits and status.
  - TRACK -> DONE when all DEPTH checked bits are set.
  - DONE -> TRACK on start (full re-arm, status cleared).
  - start while in TRACK is ignored.
- Slots:
  - W[k], k=0..DEPTH-1, holds pc_wdata of order B+k.
  - R[k], k=1..DEPTH, holds pc_rdata of order B+k.
  - Each slot has a valid bit.
  - Order arithmetic is modulo 2^64, so B+k wraps.
- Capture (TRACK only): any channel with valid whose order hits a slot writes it at the clock edge. Orders outside B..B+DEPTH are ignored.
- Effective value of a slot = stored value, else the same-cycle incoming value. This makes a predecessor and successor retiring in the same cycle, on any channels, comparable that cycle.
- Compare for pair k:
  - Fires once, when effective W[k-1] and R[k] are both valid and checked[k] is 0.
  - Full XLEN equality.
  - Sets checked[k]; checked_cnt, err and done update at that edge, i.e. visible 1 cycle after the later of the two retirements.
- Duplicate: a write to an already-valid slot, or two channels hitting the same slot in one cycle, raises duplicate order (code 2). The stored or lowest-channel value is kept.
- First error only: the error fields latch on the first error. Among simultaneous errors, lowest k wins, and mismatch beats duplicate at equal k. Later errors leave the fields unchanged; checking continues.
- done and err hold until reset or a re-arm.
- Reset mid-window returns to IDLE, discarding all slots.

Optional Feature:
- Macro RVFI_PC_CHAIN_CHECK_ASSERT_EN.
- Defined: an immediate assert in the clocked block fails on any PC mismatch compare (a duplicate also asserts), for formal use.
- Undefined: no assert statements; the status outputs are the only reporting.

Test Plan:
- NRET=1, B=10, orders 10..14 in sequence with PCs 0x100,0x104,0x108,0x10C,0x110 and wdata = next PC -> done=1 one cycle after order 14; err=0; checked_cnt=4.
- As above but order 12 has pc_rdata 0x200 -> err=1, err_code=1, err_order=12, err_expect=0x108, err_actual=0x200; done still reaches 1.
- NRET=2, order 11 on channel 0 and order 10 on channel 1 in the same cycle, correct PCs -> pair 1 compared that cycle; checked_cnt=1 on the next cycle; no err.
- Successor retired 3 cycles before predecessor (out of order) -> compare occurs on predecessor arrival; correct PCs give no err.
- B=0xFFFF_FFFF_FFFF_FFFF, DEPTH=2, orders 0xFFFF..FFFF, 0, 1 -> wrap handled, done=1, err=0.
- Order 11 retired twice -> err_code=2, err_order=11. Then reset mid-TRACK -> busy=0, err=0 next cycle.
